i2s_tx: RTL and testbench

//  Serializer that drives one stereo PCM frame per tx_data word onto an I2S link (sck/ws/sd).
//  It is the transmit end of the audio path: the receiver deserializes 32-bit frames into daf,
//  and this block serializes the processed daf output back onto the line.

---
 rtl/i2s_tx.sv | 191 +++++++++++++++++++
 tb/tb_i2s_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: serializes one stereo PCM frame per accepted tx_data word onto an
// I2S link (sck/ws/sd). A holding register decouples the valid/ready input
// from the shift register, so the next word can be accepted while the
// current frame is on the line and frames stream back to back.
//
// Ports
//   clk       in   system clock, rising-edge logic
//   n_rst     in   asynchronous active-low reset
//   en        in   1 = stream; 0 = stop after the current frame completes
//   tx_data   in   [15:0] left sample, [31:16] right sample
//   tx_valid  in   tx_data valid
//   tx_ready  out  holding register empty
//   sck       out  I2S bit clock (low half then high half per slot)
//   ws        out  I2S word select, 0 = left, 1 = right (leads MSB by one slot)
//   sd        out  I2S serial data, MSB first
//   busy      out  1 while streaming
//   underrun  out  1-clk pulse when a frame starts with no word held
module i2s_tx #(
  parameter int unsigned HALF_DIV = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        sck,
  output logic        ws,
  output logic        sd,
  output logic        busy,
  output logic        underrun
);

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned SLOT_W  = 5;
  localparam int unsigned DIV_W   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state,     w_state;
  logic [DIV_W-1:0]     r_div,       w_div;
  logic [SLOT_W-1:0]    r_slot,      w_slot;
  logic [FRAME_W-1:0]   r_hold,      w_hold;
  logic                 r_hold_full, w_hold_full;
  logic [FRAME_W-1:0]   r_shift,     w_shift;
  logic                 r_sck,       w_sck;
  logic                 r_ws,        w_ws;
  logic                 r_sd,        w_sd;
  logic                 r_tx_ready,  w_tx_ready;
  logic                 r_busy,      w_busy;
  logic                 r_underrun,  w_underrun;

  logic                 w_accept;
  logic                 w_div_last;
  logic                 w_frame_start;
  logic                 w_slot_start;

  assign w_accept   = tx_valid & r_tx_ready;
  assign w_div_last = (r_div == DIV_W'(HALF_DIV - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_slot      <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_sck       <= 1'b0;
      r_ws        <= 1'b0;
      r_sd        <= 1'b0;
      r_tx_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_div       <= w_div;
      r_slot      <= w_slot;
      r_hold      <= w_hold;
      r_hold_full <= w_hold_full;
      r_shift     <= w_shift;
      r_sck       <= w_sck;
      r_ws        <= w_ws;
      r_sd        <= w_sd;
      r_tx_ready  <= w_tx_ready;
      r_busy      <= w_busy;
      r_underrun  <= w_underrun;
    end
  end

  // Next-state, bit timing, frame loading and handshake
  always_comb begin
    w_state       = r_state;
    w_div         = r_div;
    w_slot        = r_slot;
    w_hold        = r_hold;
    w_hold_full   = r_hold_full;
    w_shift       = r_shift;
    w_sck         = r_sck;
    w_ws          = r_ws;
    w_sd          = r_sd;
    w_underrun    = 1'b0;
    w_frame_start = 1'b0;
    w_slot_start  = 1'b0;

    case (r_state)
      IDLE: begin
        w_sck  = 1'b0;
        w_ws   = 1'b0;
        w_sd   = 1'b0;
        w_div  = '0;
        w_slot = '0;
        if (en && r_hold_full) begin
          w_state       = RUN;
          w_frame_start = 1'b1;
        end
      end
      RUN: begin
        if (w_div_last) begin
          w_div = '0;
          if (!r_sck) begin
            w_sck = 1'b1;
          end else if (r_slot == SLOT_W'(FRAME_W - 1)) begin
            // End of slot 31: en is only sampled here, so mid-frame
            // changes never truncate a frame.
            if (!en) begin
              w_state = IDLE;
              w_sck   = 1'b0;
              w_ws    = 1'b0;
              w_sd    = 1'b0;
            end else begin
              w_frame_start = 1'b1;
            end
          end else begin
            w_slot_start = 1'b1;
          end
        end else begin
          w_div = DIV_W'(r_div + 1'b1);
        end
      end
      default: w_state = IDLE;
    endcase

    // Slot 0: move held word into the shifter, or send silence on underrun
    if (w_frame_start) begin
      w_sck  = 1'b0;
      w_div  = '0;
      w_slot = '0;
      w_ws   = 1'b0;
      if (r_hold_full) begin
        w_shift     = r_hold;
        w_hold_full = 1'b0;
      end else begin
        w_shift    = '0;
        w_underrun = 1'b1;
      end
      w_sd = w_shift[FRAME_W-1];
    end

    // Slots 1..31: next bit; ws goes high one slot ahead of the right MSB
    // and drops one slot ahead of the next left MSB.
    if (w_slot_start) begin
      w_sck   = 1'b0;
      w_slot  = SLOT_W'(r_slot + 1'b1);
      w_sd    = r_shift[FRAME_W-2];
      w_shift = {r_shift[FRAME_W-2:0], 1'b0};
      w_ws    = (r_slot >= SLOT_W'(14)) && (r_slot <= SLOT_W'(29));
    end

    // Holding register stores the word in line order {left, right}
    if (w_accept) begin
      w_hold      = {tx_data[15:0], tx_data[31:16]};
      w_hold_full = 1'b1;
    end
  end

  assign w_tx_ready = ~w_hold_full;
  assign w_busy     = (w_state == RUN);

  assign tx_ready = r_tx_ready;
  assign sck      = r_sck;
  assign ws       = r_ws;
  assign sd       = r_sd;
  assign busy     = r_busy;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: one instance at HALF_DIV=1 for framing,
// streaming, underrun and stop/restart, one at HALF_DIV=3 for slot timing
// and mid-frame reset.
module tb_i2s_tx;

  logic        clk;
  int          checks;
  int          errors;

  logic        rst1_n, en1, valid1;
  logic [31:0] data1;
  logic        ready1, sck1, ws1, sd1, busy1, under1;

  logic        rst3_n, en3, valid3;
  logic [31:0] data3;
  logic        ready3, sck3, ws3, sd3, busy3, under3;

  i2s_tx #(.HALF_DIV(1)) u_dut1 (
    .clk(clk), .n_rst(rst1_n), .en(en1), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .sck(sck1), .ws(ws1), .sd(sd1), .busy(busy1), .underrun(under1)
  );

  i2s_tx #(.HALF_DIV(3)) u_dut3 (
    .clk(clk), .n_rst(rst3_n), .en(en3), .tx_data(data3), .tx_valid(valid3),
    .tx_ready(ready3), .sck(sck3), .ws(ws3), .sd(sd3), .busy(busy3), .underrun(under3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checks one whole frame on dut1, starting with the slot-0 edge.
  // rdy_mode: 0 = unchecked, 1 = ready only in first cycle, 2 = ready throughout.
  // At c==1 tx_valid/tx_data are updated; at c==en_c en is set to en_v.
  task automatic check_frame(input logic [31:0] exp_bits, input logic exp_under,
                             input int rdy_mode, input logic nv, input logic [31:0] nd,
                             input int en_c, input logic en_v, input string name);
    int   slot;
    logic e_sck, e_sd, e_ws, e_un, e_rdy;
    @(posedge clk);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      slot  = c / 2;
      e_sck = (c % 2) == 1;
      e_sd  = exp_bits[31 - slot];
      e_ws  = (slot >= 15) && (slot <= 30);
      e_un  = exp_under && (c == 0);
      e_rdy = (rdy_mode == 2) || (c == 0);
      checks++;
      if (sck1 !== e_sck) begin
        errors++; $display("FAIL %s sck c=%0d got %b exp %b", name, c, sck1, e_sck);
      end
      checks++;
      if (sd1 !== e_sd) begin
        errors++; $display("FAIL %s sd slot=%0d got %b exp %b", name, slot, sd1, e_sd);
      end
      checks++;
      if (ws1 !== e_ws) begin
        errors++; $display("FAIL %s ws slot=%0d got %b exp %b", name, slot, ws1, e_ws);
      end
      checks++;
      if (under1 !== e_un) begin
        errors++; $display("FAIL %s underrun c=%0d got %b exp %b", name, c, under1, e_un);
      end
      checks++;
      if (busy1 !== 1'b1) begin
        errors++; $display("FAIL %s busy c=%0d got %b exp 1", name, c, busy1);
      end
      if (rdy_mode != 0) begin
        checks++;
        if (ready1 !== e_rdy) begin
          errors++; $display("FAIL %s tx_ready c=%0d got %b exp %b", name, c, ready1, e_rdy);
        end
      end
      if (c == 1) begin
        valid1 = nv;
        data1  = nd;
      end
      if (c == en_c) en1 = en_v;
    end
  endtask

  task automatic check_idle(input int n, input logic exp_rdy, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ({busy1, sck1, sd1, ws1, under1} !== 5'b0) begin
        errors++;
        $display("FAIL %s idle outputs busy/sck/sd/ws/under got %b exp 00000", name,
                 {busy1, sck1, sd1, ws1, under1});
      end
      checks++;
      if (ready1 !== exp_rdy) begin
        errors++; $display("FAIL %s idle tx_ready got %b exp %b", name, ready1, exp_rdy);
      end
    end
  endtask

  task automatic test_reset();
    rst1_n = 1'b1; rst3_n = 1'b1;
    en1 = 1'b0; valid1 = 1'b0; data1 = '0;
    en3 = 1'b0; valid3 = 1'b0; data3 = '0;
    #1;
    rst1_n = 1'b0; rst3_n = 1'b0;
    #1;
    checks++;
    if ({sck1, ws1, sd1, busy1, under1, ready1} !== 6'b000001) begin
      errors++;
      $display("FAIL reset1 sck/ws/sd/busy/under/ready got %b exp 000001",
               {sck1, ws1, sd1, busy1, under1, ready1});
    end
    checks++;
    if ({sck3, ws3, sd3, busy3, under3, ready3} !== 6'b000001) begin
      errors++;
      $display("FAIL reset3 sck/ws/sd/busy/under/ready got %b exp 000001",
               {sck3, ws3, sd3, busy3, under3, ready3});
    end
    @(negedge clk);
    rst1_n = 1'b1; rst3_n = 1'b1;
    check_idle(2, 1'b1, "post_reset");
  endtask

  // Single word: latency, framing, then an underrun frame
  task automatic test_single_and_underrun();
    en1 = 1'b1; valid1 = 1'b1; data1 = 32'hBEEF_1234;
    @(posedge clk);
    #1 valid1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, ready1, sck1} !== 3'b000) begin
      errors++; $display("FAIL latency busy/ready/sck got %b exp 000", {busy1, ready1, sck1});
    end
    check_frame(32'h1234_BEEF, 1'b0, 2, 1'b0, 32'h0, -1, 1'b1, "single");
    check_frame(32'h0000_0000, 1'b1, 2, 1'b0, 32'h0, 1, 1'b0, "underrun");
    check_idle(3, 1'b1, "after_underrun");
  endtask

  task automatic test_back_to_back();
    en1 = 1'b1; valid1 = 1'b1; data1 = 32'hA5A5_5A5A;
    @(posedge clk);
    #1 data1 = 32'h1111_2222;
    check_frame(32'h5A5A_A5A5, 1'b0, 1, 1'b1, 32'hFFFF_0000, -1, 1'b1, "b2b_w0");
    check_frame(32'h2222_1111, 1'b0, 1, 1'b1, 32'h0F0F_C3C3, -1, 1'b1, "b2b_w1");
    check_frame(32'h0000_FFFF, 1'b0, 1, 1'b0, 32'h0, -1, 1'b1, "b2b_w2");
    check_frame(32'hC3C3_0F0F, 1'b0, 2, 1'b0, 32'h0, 1, 1'b0, "b2b_w3");
    check_idle(3, 1'b1, "after_b2b");
  endtask

  // en dropped at slot 10: frame completes, held word waits for en
  task automatic test_stop_restart();
    en1 = 1'b1; valid1 = 1'b1; data1 = 32'hCAFE_F00D;
    @(posedge clk);
    #1 data1 = 32'h0123_4567;
    check_frame(32'hF00D_CAFE, 1'b0, 1, 1'b0, 32'h0, 20, 1'b0, "stop_a");
    check_idle(5, 1'b0, "stopped_held");
    en1 = 1'b1;
    check_frame(32'h4567_0123, 1'b0, 2, 1'b0, 32'h0, 1, 1'b0, "restart_b");
    check_idle(2, 1'b1, "after_restart");
  endtask

  task automatic test_reset_midframe1();
    en1 = 1'b1; valid1 = 1'b1; data1 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 valid1 = 1'b0;
    @(posedge clk);
    repeat (8) @(negedge clk);
    checks++;
    if ({sck1, sd1, busy1} !== 3'b111) begin
      errors++; $display("FAIL pre_reset1 sck/sd/busy got %b exp 111", {sck1, sd1, busy1});
    end
    #2 rst1_n = 1'b0;
    #1;
    checks++;
    if ({sck1, ws1, sd1, busy1, under1, ready1} !== 6'b000001) begin
      errors++;
      $display("FAIL midreset1 sck/ws/sd/busy/under/ready got %b exp 000001",
               {sck1, ws1, sd1, busy1, under1, ready1});
    end
    en1 = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    check_idle(3, 1'b1, "after_midreset1");
  endtask

  // HALF_DIV=3: 6-clk slots, sd high only in slots 15/16, reset at slot 20
  task automatic test_half_div3();
    int   slot;
    logic e_sck, e_sd, e_ws;
    @(negedge clk);
    en3 = 1'b1; valid3 = 1'b1; data3 = 32'h8000_0001;
    @(posedge clk);
    #1 valid3 = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 124; c++) begin
      @(negedge clk);
      slot  = c / 6;
      e_sck = (c % 6) >= 3;
      e_sd  = (slot == 15) || (slot == 16);
      e_ws  = (slot >= 15) && (slot <= 30);
      checks++;
      if (sck3 !== e_sck) begin
        errors++; $display("FAIL hd3 sck c=%0d got %b exp %b", c, sck3, e_sck);
      end
      checks++;
      if (sd3 !== e_sd) begin
        errors++; $display("FAIL hd3 sd slot=%0d got %b exp %b", slot, sd3, e_sd);
      end
      checks++;
      if (ws3 !== e_ws) begin
        errors++; $display("FAIL hd3 ws slot=%0d got %b exp %b", slot, ws3, e_ws);
      end
      checks++;
      if ({busy3, under3} !== 2'b10) begin
        errors++; $display("FAIL hd3 busy/under c=%0d got %b exp 10", c, {busy3, under3});
      end
    end
    #2 rst3_n = 1'b0;
    #1;
    checks++;
    if ({sck3, ws3, sd3, busy3, under3, ready3} !== 6'b000001) begin
      errors++;
      $display("FAIL midreset3 sck/ws/sd/busy/under/ready got %b exp 000001",
               {sck3, ws3, sd3, busy3, under3, ready3});
    end
    en3 = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_and_underrun();
    test_back_to_back();
    test_stop_restart();
    test_reset_midframe1();
    test_half_div3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
